cpu_hazard_unit: RTL
====================

# cpu_hazard_unit

Pipeline hazard and stall controller for the in-order CPU core. Sits directly upstream of the forwarding unit's bypass muxes and drives the stall, bubble and flush controls of the IF/ID, ID/EX and EX/MEM pipeline registers. It covers every case forwarding cannot resolve: load-use dependencies, data-cache and instruction-cache misses, taken branches and committed exceptions. It also keeps a stall-cycle performance counter.

## Interface
Parameters:
- REG_W, 5, register-index width
- LOAD_USE_STALL, 1, bubbles inserted per load-use hazard (1..7)
- CNT_W, 32, stall counter width

Ports:
- clock  in  1  clock
- reset  in  1  synchronous, active-high
- valid_dec  in  1  decode stage holds a valid instruction
- ra_dec, rb_dec  in  REG_W  decode source registers
- uses_ra_dec, uses_rb_dec  in  1  source operand actually read
- valid_ex  in  1  execute stage holds a valid instruction
- load_ex  in  1  execute instruction is a load
- rd_ex  in  REG_W  execute destination register
- branch_taken_ex  in  1  branch resolved taken in EX
- exception_commit  in  1  exception taken at commit (one-cycle pulse)
- dcache_miss  in  1  level; high while a MEM-stage miss is pending
- dcache_ready  in  1  one-cycle pulse; miss data returned
- icache_miss  in  1  level; high while a fetch miss is pending
- stall_if, stall_id, stall_ex, stall_mem  out  1  hold the stage register
- bubble_id, bubble_ex  out  1  load a NOP into the stage register
- flush_id, flush_ex, flush_mem  out  1  invalidate the stage register
- dcache_abort  out  1  cancel the outstanding data miss
- stall_cycles  out  CNT_W  saturating count of cycles with stall_if=1

## Operation
- State register: RUN, LU_STALL, DMISS. Lu_cnt is 3 bits.
- All control outputs are combinational from state and inputs (Mealy). State, lu_cnt and stall_cycles update on the rising edge.
- Load-use hazard (lu): valid_dec & valid_ex & load_ex & rd_ex!=0 & ((uses_ra_dec & ra_dec==rd_ex) | (uses_rb_dec & rb_dec==rd_ex)). Register 0 reads as zero and never creates a hazard.
- Priority in every state: exception_commit > dcache_miss/DMISS > branch_taken_ex > lu/LU_STALL > icache_miss.
- exception_commit: flush_id=flush_ex=flush_mem=1, all stalls 0, lu_cnt cleared. If the state is DMISS, also dcache_abort=1. Next state RUN.
- RUN, dcache_miss=1: stall_if/id/ex/mem=1. Next state DMISS.
- DMISS: stall_if/id/ex/mem=1 while dcache_ready=0. In the dcache_ready cycle all stalls are 0 and the next state is RUN. A pending LU_STALL is lost: lu is re-evaluated after the load advances.
- branch_taken_ex (RUN or LU_STALL): flush_id=1, bubble_ex=1, stalls 0. Next state RUN. icache_miss is ignored that cycle because the fetch is redirected.
- RUN, lu=1: stall_if=stall_id=1, bubble_ex=1. If LOAD_USE_STALL>1, next state LU_STALL with lu_cnt=LOAD_USE_STALL-1; otherwise stay in RUN.
- LU_STALL: same outputs as the lu case, lu_cnt decrements each cycle. Return to RUN when lu_cnt==1.
- icache_miss (RUN, no higher event): stall_if=1, bubble_id=1.
- stall_cycles increments in every cycle with stall_if=1 and saturates at all-ones.

## Timing
- Reset: state RUN, lu_cnt=0, stall_cycles=0. While reset=1 every control output is 0 regardless of inputs.
- Hazard-to-control latency: 0 cycles (same cycle). State effects apply from the next cycle.
- Load-use with LOAD_USE_STALL=N yields exactly N cycles with bubble_ex=1, after which the dependent instruction issues with forwarding from commit or wb.
- A dcache miss asserted for k cycles before the ready pulse stalls for k cycles. The ready cycle itself is not stalled.
- Simultaneous dcache_ready and exception_commit: the exception wins, dcache_abort=1.
- Simultaneous lu and icache_miss: lu controls apply and icache_miss is served afterwards. The level input remains high, so it is not lost.
- A reset asserted mid-DMISS or mid-LU_STALL returns the block to RUN on the next edge. No abort pulse is issued.

## Test plan
- Load r3 in EX, decode reads r3 on ra, N=1: one cycle with stall_if/stall_id/bubble_ex=1, then all 0. stall_cycles=1.
- N=3, same hazard: bubble_ex high for exactly 3 consecutive cycles. State sequence RUN, LU_STALL, LU_STALL, RUN.
- Load r0 or uses_ra_dec=0 with a matching index: no stall.
- dcache_miss high 5 cycles then dcache_ready: stall_mem=1 for 5 cycles, 0 in the ready cycle. stall_cycles=5.
- exception_commit in the 3rd DMISS cycle: flush_id/ex/mem=1 and dcache_abort=1 for one cycle. Stalls 0 the next cycle, state RUN.
- branch_taken_ex together with lu and icache_miss: only flush_id=1 and bubble_ex=1. stall_if=0, next state RUN.

Source files
------------

// File: rtl/cpu_hazard_unit_if.sv
// rtl/cpu_hazard_unit_if.sv - pipeline hazard controller signal bundle
// master: pipeline datapath side; slave: cpu_hazard_unit.
interface cpu_hazard_unit_if #(
  parameter int REG_W = 5,
  parameter int CNT_W = 32
);
  logic             valid_dec;
  logic [REG_W-1:0] ra_dec;
  logic [REG_W-1:0] rb_dec;
  logic             uses_ra_dec;
  logic             uses_rb_dec;
  logic             valid_ex;
  logic             load_ex;
  logic [REG_W-1:0] rd_ex;
  logic             branch_taken_ex;
  logic             exception_commit;
  logic             dcache_miss;
  logic             dcache_ready;
  logic             icache_miss;
  logic             stall_if;
  logic             stall_id;
  logic             stall_ex;
  logic             stall_mem;
  logic             bubble_id;
  logic             bubble_ex;
  logic             flush_id;
  logic             flush_ex;
  logic             flush_mem;
  logic             dcache_abort;
  logic [CNT_W-1:0] stall_cycles;

  modport master (
    output valid_dec, ra_dec, rb_dec, uses_ra_dec, uses_rb_dec,
           valid_ex, load_ex, rd_ex, branch_taken_ex, exception_commit,
           dcache_miss, dcache_ready, icache_miss,
    input  stall_if, stall_id, stall_ex, stall_mem, bubble_id, bubble_ex,
           flush_id, flush_ex, flush_mem, dcache_abort, stall_cycles
  );

  modport slave (
    input  valid_dec, ra_dec, rb_dec, uses_ra_dec, uses_rb_dec,
           valid_ex, load_ex, rd_ex, branch_taken_ex, exception_commit,
           dcache_miss, dcache_ready, icache_miss,
    output stall_if, stall_id, stall_ex, stall_mem, bubble_id, bubble_ex,
           flush_id, flush_ex, flush_mem, dcache_abort, stall_cycles
  );
endinterface

// File: rtl/cpu_hazard_unit.sv
// rtl/cpu_hazard_unit.sv - load-use, cache-miss, branch and exception stall/flush control
// Mealy controller; outputs are combinational from state and the current hazard inputs.
module cpu_hazard_unit #(
  parameter int REG_W          = 5,
  parameter int LOAD_USE_STALL = 1,
  parameter int CNT_W          = 32
) (
  input  logic               clock,
  input  logic               reset,
  cpu_hazard_unit_if.slave   hz
);
  typedef enum logic [1:0] {RUN, LU_STALL, DMISS} state_t;

  localparam logic [REG_W-1:0] ZERO_REG = '0;
  localparam logic [2:0]       LU_INIT  = 3'(LOAD_USE_STALL - 1);

  state_t           state, state_nxt;
  logic [2:0]       lu_cnt, lu_cnt_nxt;
  logic [CNT_W-1:0] stall_cnt;
  logic             lu;
  logic             s_if, s_id, s_ex, s_mem, b_id, b_ex, f_id, f_ex, f_mem, abort;

  // r0 is hardwired to zero, so a load targeting it never creates a dependency
  assign lu = hz.valid_dec && hz.valid_ex && hz.load_ex && (hz.rd_ex != ZERO_REG) &&
              ((hz.uses_ra_dec && (hz.ra_dec == hz.rd_ex)) ||
               (hz.uses_rb_dec && (hz.rb_dec == hz.rd_ex)));

  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= RUN;
      lu_cnt    <= '0;
      stall_cnt <= '0;
    end else begin
      state  <= state_nxt;
      lu_cnt <= lu_cnt_nxt;
      if (s_if && !(&stall_cnt)) stall_cnt <= stall_cnt + 1'b1;
    end
  end

  always_comb begin
    state_nxt  = state;
    lu_cnt_nxt = lu_cnt;
    s_if = 1'b0; s_id = 1'b0; s_ex = 1'b0; s_mem = 1'b0;
    b_id = 1'b0; b_ex = 1'b0;
    f_id = 1'b0; f_ex = 1'b0; f_mem = 1'b0;
    abort = 1'b0;
    if (reset) begin
      state_nxt  = RUN;
      lu_cnt_nxt = '0;
    end else if (hz.exception_commit) begin
      f_id = 1'b1; f_ex = 1'b1; f_mem = 1'b1;
      abort      = (state == DMISS);
      state_nxt  = RUN;
      lu_cnt_nxt = '0;
    end else if (state == DMISS) begin
      // the load advances in the ready cycle; any interrupted load-use stall is re-detected
      if (hz.dcache_ready) begin
        state_nxt  = RUN;
        lu_cnt_nxt = '0;
      end else begin
        s_if = 1'b1; s_id = 1'b1; s_ex = 1'b1; s_mem = 1'b1;
      end
    end else if (hz.dcache_miss) begin
      s_if = 1'b1; s_id = 1'b1; s_ex = 1'b1; s_mem = 1'b1;
      state_nxt  = DMISS;
      lu_cnt_nxt = '0;
    end else if (hz.branch_taken_ex) begin
      f_id = 1'b1; b_ex = 1'b1;
      state_nxt  = RUN;
      lu_cnt_nxt = '0;
    end else if (state == LU_STALL) begin
      s_if = 1'b1; s_id = 1'b1; b_ex = 1'b1;
      lu_cnt_nxt = lu_cnt - 3'd1;
      if (lu_cnt == 3'd1) state_nxt = RUN;
    end else if (lu) begin
      s_if = 1'b1; s_id = 1'b1; b_ex = 1'b1;
      if (LOAD_USE_STALL > 1) begin
        state_nxt  = LU_STALL;
        lu_cnt_nxt = LU_INIT;
      end
    end else if (hz.icache_miss) begin
      s_if = 1'b1; b_id = 1'b1;
    end
  end

  assign hz.stall_if     = s_if;
  assign hz.stall_id     = s_id;
  assign hz.stall_ex     = s_ex;
  assign hz.stall_mem    = s_mem;
  assign hz.bubble_id    = b_id;
  assign hz.bubble_ex    = b_ex;
  assign hz.flush_id     = f_id;
  assign hz.flush_ex     = f_ex;
  assign hz.flush_mem    = f_mem;
  assign hz.dcache_abort = abort;
  assign hz.stall_cycles = stall_cnt;
endmodule
